datapath_ctrl: RTL and testbench
================================

Name: datapath_ctrl

Overview:
- Multicycle control sequencer for the 64-bit load/store/add/sub datapath: register file, adder/subtractor, data memory, operand mux and writeback mux.
- Accepts one 32-bit RV64-encoded instruction at a time via valid/ready.
- Decodes the instruction and drives the datapath control lines that a bench would otherwise drive by hand: register addresses, write enables, add/sub select, mux select and immediate.
- Sits between the instruction source and the datapath.

Parameters:
- XLEN, 64, datapath width; width of imm.
- RAW, 5, register address width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- instr  in  32  instruction word
- instr_valid  in  1  instr is valid
- instr_ready  out  1  controller can accept an instruction
- Ra  out  RAW  register file read port A address (rs1)
- Rb  out  RAW  register file read port B address (rs2)
- Rw  out  RAW  register file write address (rd)
- weReg  out  1  register file write enable
- weMem  out  1  data memory write enable
- sinal  out  1  adder op: 0 = add, 1 = subtract
- sinalMux  out  1  1 = Rb operand and adder-sum writeback; 0 = imm operand and memory-data writeback
- imm  out  XLEN  sign-extended immediate (C input of operand mux)
- done  out  1  one-cycle pulse when an instruction retires
- illegal  out  1  one-cycle pulse on an undecodable instruction
- retired  out  32  count of retired instructions

Behaviour:
- Decode, on the latched instruction ir:
  - LD: opcode 0000011, funct3 011. imm = sext(ir[31:20]).
  - SD: opcode 0100011, funct3 011. imm = sext({ir[31:25], ir[11:7]}).
  - ADD: opcode 0110011, funct3 000, funct7 0000000.
  - SUB: same as ADD but funct7 0100000.
  - Anything else is ILLEGAL.
- Field mapping: Ra = ir[19:15], Rb = ir[24:20], Rw = ir[11:7].
  - These are held stable from DECODE until the return to IDLE.
  - Rw = 0 is written normally; register 0 is not hardwired to zero.
- Handshake:
  - instr_ready = 1 only in IDLE while rst = 0.
  - Transfer occurs on an edge with instr_valid & instr_ready; ir is loaded on that edge.
  - instr is ignored in all other states.
- States and transitions:
  - IDLE -> DECODE on transfer.
  - DECODE -> EXEC if decode is legal; DECODE -> ILLEGAL otherwise.
  - EXEC -> MEM for LD/SD; EXEC -> WB for ADD/SUB.
  - MEM -> WB for LD; MEM -> IDLE for SD.
  - WB -> IDLE.
  - ILLEGAL -> IDLE.
- Control per state:
  - DECODE, EXEC, MEM, WB: sinal = 1 for SUB, else 0. sinalMux = 1 for ADD/SUB, 0 for LD/SD. imm is valid.
  - MEM with SD: weMem = 1 for exactly one cycle.
  - WB: weReg = 1 for exactly one cycle.
  - weReg and weMem are 0 in every other state.
- done pulses in the final cycle of each legal instruction: WB for LD/ADD/SUB, MEM for SD.
  - retired increments on that same edge and wraps 0xFFFFFFFF -> 0.
- illegal pulses in the ILLEGAL state. No write enable is asserted and retired is unchanged.
- Latency from transfer edge to done cycle:
  - ADD/SUB and SD: 3 cycles.
  - LD: 4 cycles.
- Back-to-back operation: instr_ready returns the cycle after done or illegal. The minimum issue interval is 4 cycles (5 for LD).
- weReg and weMem are ANDed with !rst, so no write occurs on an edge where rst = 1.
- Reset, including mid-operation:
  - State -> IDLE; ir, imm, Ra, Rb, Rw -> 0; retired -> 0.
  - weReg, weMem, sinal, sinalMux, done, illegal -> 0.
  - instr_ready = 0 while rst = 1, and 1 in the first cycle after reset deasserts.
- Simultaneous rst and instr_valid: rst wins and no transfer occurs.

Test Plan:
1. Reset, then ADD instr 0x002081B3 (rd = 3, rs1 = 1, rs2 = 2) -> Ra = 1, Rb = 2, Rw = 3, sinal = 0, sinalMux = 1; single weReg pulse 3 cycles after the transfer edge; done coincident with it; retired = 1.
2. SUB instr 0x40308233 (rd = 4, rs1 = 1, rs2 = 3) -> sinal = 1, sinalMux = 1, Rw = 4; one weReg pulse; weMem stays 0.
3. LD instr 0x0100B103 (rd = 2, rs1 = 1, imm = 16) -> imm = 16, sinalMux = 0; weMem never set; weReg pulses 4 cycles after the transfer edge. Repeat with imm field 0xFF8 -> imm = 0xFFFFFFFFFFFFFFF8.
4. SD instr 0x0020B423 (rs1 = 1, rs2 = 2, imm = 8) -> imm = 8, Ra = 1, Rb = 2; one weMem pulse; weReg stays 0; done pulses 3 cycles after the transfer edge.
5. Illegal 0xFFFFFFFF -> illegal pulses once; no write enables; retired unchanged; instr_ready returns to 1.
6. Assert rst during EXEC of an LD -> no weReg pulse; outputs at reset values; the next ADD is accepted and retires normally with retired = 1. Also hold instr_valid high continuously across 3 instructions -> exactly 3 transfers and 3 done pulses.

Source files
------------

// File: rtl/datapath_ctrl.sv
// datapath_ctrl: multicycle sequencer for the 64-bit LD/SD/ADD/SUB datapath.
// Ports: instr/instr_valid/instr_ready in; Ra/Rb/Rw, weReg/weMem, sinal/sinalMux, imm, done/illegal/retired out.
module datapath_ctrl #(
  parameter int XLEN = 64,
  parameter int RAW  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instr,
  input  logic            instr_valid,
  output logic            instr_ready,
  output logic [RAW-1:0]  Ra,
  output logic [RAW-1:0]  Rb,
  output logic [RAW-1:0]  Rw,
  output logic            weReg,
  output logic            weMem,
  output logic            sinal,
  output logic            sinalMux,
  output logic [XLEN-1:0] imm,
  output logic            done,
  output logic            illegal,
  output logic [31:0]     retired
);

  typedef enum logic [2:0] {
    OP_ILL,
    OP_LD,
    OP_SD,
    OP_ADD,
    OP_SUB
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_ILL
  } state_e;

  state_e          state;
  op_e             ir_op;
  op_e             op_in;
  logic            we_reg_q;
  logic            we_mem_q;
  logic [XLEN-1:0] imm_in;

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];

  // The word is decoded as it is latched; the latched class then
  // steers every later state.
  always_comb begin
    op_in = OP_ILL;
    unique case (1'b1)
      (opc == 7'b0000011 && f3 == 3'b011):
        op_in = OP_LD;
      (opc == 7'b0100011 && f3 == 3'b011):
        op_in = OP_SD;
      (opc == 7'b0110011 && f3 == 3'b000
        && f7 == 7'b0000000):
        op_in = OP_ADD;
      (opc == 7'b0110011 && f3 == 3'b000
        && f7 == 7'b0100000):
        op_in = OP_SUB;
      default:
        op_in = OP_ILL;
    endcase
  end

  always_comb begin
    imm_in = '0;
    unique case (op_in)
      OP_LD:
        imm_in = {{(XLEN-12){instr[31]}},
                  instr[31:20]};
      OP_SD:
        imm_in = {{(XLEN-12){instr[31]}},
                  instr[31:25], instr[11:7]};
      default:
        imm_in = '0;
    endcase
  end

  // Write strobes are gated by rst so an edge with rst high never writes.
  assign weReg       = we_reg_q & ~rst;
  assign weMem       = we_mem_q & ~rst;
  assign instr_ready = (state == S_IDLE) & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      ir_op    <= OP_ILL;
      Ra       <= '0;
      Rb       <= '0;
      Rw       <= '0;
      imm      <= '0;
      sinal    <= 1'b0;
      sinalMux <= 1'b0;
      we_reg_q <= 1'b0;
      we_mem_q <= 1'b0;
      done     <= 1'b0;
      illegal  <= 1'b0;
      retired  <= '0;
    end else begin
      we_reg_q <= 1'b0;
      we_mem_q <= 1'b0;
      done     <= 1'b0;
      illegal  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (instr_valid) begin
            state    <= S_DECODE;
            ir_op    <= op_in;
            Ra       <= RAW'(instr[19:15]);
            Rb       <= RAW'(instr[24:20]);
            Rw       <= RAW'(instr[11:7]);
            imm      <= imm_in;
            sinal    <= (op_in == OP_SUB);
            sinalMux <= (op_in == OP_ADD)
                     || (op_in == OP_SUB);
          end
        end
        S_DECODE: begin
          if (ir_op == OP_ILL) begin
            state   <= S_ILL;
            illegal <= 1'b1;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (ir_op == OP_LD || ir_op == OP_SD) begin
            state <= S_MEM;
            // A store finishes in MEM.
            if (ir_op == OP_SD) begin
              we_mem_q <= 1'b1;
              done     <= 1'b1;
              retired  <= retired + 32'd1;
            end
          end else begin
            state    <= S_WB;
            we_reg_q <= 1'b1;
            done     <= 1'b1;
            retired  <= retired + 32'd1;
          end
        end
        S_MEM: begin
          if (ir_op == OP_LD) begin
            state    <= S_WB;
            we_reg_q <= 1'b1;
            done     <= 1'b1;
            retired  <= retired + 32'd1;
          end else begin
            state <= S_IDLE;
          end
        end
        S_WB: begin
          state <= S_IDLE;
        end
        S_ILL: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_datapath_ctrl.sv
// tb_datapath_ctrl: directed and random checks of datapath_ctrl
// against an instruction-level reference model.
module tb_datapath_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [4:0]  Ra, Rb, Rw;
  logic        weReg, weMem, sinal, sinalMux;
  logic [63:0] imm;
  logic        done, illegal;
  logic [31:0] retired;

  datapath_ctrl #(.XLEN(64), .RAW(5)) dut (
    .clk(clk), .rst(rst),
    .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .Ra(Ra), .Rb(Rb), .Rw(Rw),
    .weReg(weReg), .weMem(weMem),
    .sinal(sinal), .sinalMux(sinalMux),
    .imm(imm), .done(done), .illegal(illegal),
    .retired(retired)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_ret = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Instruction class: 0 illegal, 1 LD, 2 SD, 3 ADD, 4 SUB
  function automatic int kind_of(input logic [31:0] w);
    if (w[6:0] == 7'h03 && w[14:12] == 3'd3) return 1;
    if (w[6:0] == 7'h23 && w[14:12] == 3'd3) return 2;
    if (w[6:0] == 7'h33 && w[14:12] == 3'd0
        && w[31:25] == 7'h00) return 3;
    if (w[6:0] == 7'h33 && w[14:12] == 3'd0
        && w[31:25] == 7'h20) return 4;
    return 0;
  endfunction

  function automatic logic [63:0] imm_of(input logic [31:0] w, input int k);
    longint v;
    logic [11:0] f;
    f = (k == 1) ? w[31:20] : {w[31:25], w[11:7]};
    v = longint'(f);
    if (v >= 2048) v = v - 4096;
    return 64'(v);
  endfunction

  task automatic issue(input logic [31:0] w);
    int k, lat;
    bit got, last, wr;
    k   = kind_of(w);
    lat = (k == 0) ? 2 : (k == 1) ? 4 : 3;
    wr  = (k == 1 || k == 3 || k == 4);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = instr_ready;
    end
    chk("ready_wait", 64'(got), 64'd1);
    if (!got) return;
    instr = w;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    instr = $urandom;
    if (k != 0) exp_ret = exp_ret + 32'd1;
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      last = (c == lat);
      chk("ready_busy", 64'(instr_ready), 64'd0);
      chk("weReg", 64'(weReg), 64'(last && wr));
      chk("weMem", 64'(weMem), 64'(last && k == 2));
      chk("done", 64'(done), 64'(last && k != 0));
      chk("illegal", 64'(illegal), 64'(last && k == 0));
      if (k != 0) begin
        chk("Ra", 64'(Ra), 64'(w[19:15]));
        chk("Rb", 64'(Rb), 64'(w[24:20]));
        chk("Rw", 64'(Rw), 64'(w[11:7]));
        chk("sinal", 64'(sinal), 64'(k == 4));
        chk("sinalMux", 64'(sinalMux), 64'(k >= 3));
        if (k == 1 || k == 2)
          chk("imm", imm, imm_of(w, k));
      end
    end
    @(negedge clk);
    chk("ready_back", 64'(instr_ready), 64'd1);
    chk("retired", 64'(retired), 64'(exp_ret));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int xfers, dones;
    rst = 1'b1;
    instr_valid = 1'b0;
    instr = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(instr_ready), 64'd0);
    chk("rst_weReg", 64'(weReg), 64'd0);
    chk("rst_weMem", 64'(weMem), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_illegal", 64'(illegal), 64'd0);
    chk("rst_retired", 64'(retired), 64'd0);
    chk("rst_Ra", 64'({Ra, Rb, Rw}), 64'd0);
    chk("rst_imm", imm, 64'd0);
    chk("rst_sinal", 64'({sinal, sinalMux}), 64'd0);
    rst = 1'b0;
    #1 chk("ready_after_rst", 64'(instr_ready), 64'd1);

    issue(32'h002081B3);
    issue(32'h40308233);
    issue(32'h0100B103);
    issue(32'hFF80B103);
    issue(32'h0020B423);
    issue(32'hFFFFFFFF);

    // Reset while an LD is in EXEC, with a new word offered under reset
    @(negedge clk);
    instr = 32'h0100B103;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    instr = 32'h002081B3;
    instr_valid = 1'b1;
    #1 chk("ready_in_rst", 64'(instr_ready), 64'd0);
    @(negedge clk);
    chk("mid_rst_weReg", 64'(weReg), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_regs", 64'({Ra, Rb, Rw}), 64'd0);
    chk("mid_rst_imm", imm, 64'd0);
    chk("mid_rst_ctl", 64'({sinal, sinalMux, illegal, weMem}), 64'd0);
    chk("mid_rst_retired", 64'(retired), 64'd0);
    rst = 1'b0;
    instr_valid = 1'b0;
    exp_ret = 0;
    #1 chk("ready_first", 64'(instr_ready), 64'd1);
    @(negedge clk);
    chk("no_late_wb", 64'(weReg), 64'd0);
    chk("no_xfer_in_rst", 64'(instr_ready), 64'd1);
    issue(32'h002081B3);

    // Reset landing in the WB cycle must suppress the write strobe
    @(negedge clk);
    instr = 32'h002081B3;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("wb_weReg", 64'(weReg), 64'd1);
    rst = 1'b1;
    #1 chk("wb_weReg_gated", 64'(weReg), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_ret = 0;
    #1 chk("wb_rst_retired", 64'(retired), 64'd0);

    // instr_valid held high across three ADDs
    @(negedge clk);
    xfers = 0;
    dones = 0;
    instr = 32'h002081B3;
    instr_valid = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (instr_ready && instr_valid) xfers++;
      if (done) dones++;
      @(negedge clk);
    end
    instr_valid = 1'b0;
    exp_ret = exp_ret + 32'd3;
    chk("b2b_xfers", 64'(xfers), 64'd3);
    chk("b2b_dones", 64'(dones), 64'd3);
    chk("b2b_retired", 64'(retired), 64'(exp_ret));

    for (int n = 0; n < 40; n++) begin
      logic [31:0] w;
      int t;
      t = $urandom_range(0, 4);
      w = $urandom;
      case (t)
        0: w = {w[31:20], w[19:15], 3'b011, w[11:7], 7'b0000011};
        1: w = {w[31:15], 3'b011, w[11:7], 7'b0100011};
        2: w = {7'b0000000, w[24:15], 3'b000, w[11:7], 7'b0110011};
        3: w = {7'b0100000, w[24:15], 3'b000, w[11:7], 7'b0110011};
        default: w = w;
      endcase
      issue(w);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
